// File: rtl/serial_packet_tx.sv
// -----------------------------------------------------------------------------
// serial_packet_tx
//
// Transmit side of the single-wire serial packet link. A packet is taken over a
// valid/ready handshake and sent LSB first on S_data as
//   start (0), PKT_W data bits, [even parity], STOP_BITS stop bits (1).
// The line idles at 1. All outputs come straight from flops.
//
// Optional feature macro:
//   TX_PARITY_EN  - when defined, an even-parity bit (^packet) is sent between
//                   the last data bit and the first stop bit.
//
// Parameters:
//   PKT_W      packet width in bits
//   STOP_BITS  number of stop-bit cycles (1..3)
//
// Ports:
//   Clk_S          in   link clock, all logic on posedge
//   Rst_n          in   asynchronous active-low reset
//   TX_Data_Valid  in   upstream offers a packet on TX_Data
//   TX_Data        in   packet, captured only on accept (valid && ready)
//   TX_Ready       out  block can accept a packet this cycle
//   TX_Busy        out  a frame is in flight (state != IDLE)
//   TX_Done        out  one-cycle pulse on the first IDLE cycle after a frame
//   S_data         out  registered serial line
// -----------------------------------------------------------------------------
module serial_packet_tx #(
    parameter int PKT_W     = 55,
    parameter int STOP_BITS = 1
) (
    input  logic             Clk_S,
    input  logic             Rst_n,
    input  logic             TX_Data_Valid,
    input  logic [PKT_W-1:0] TX_Data,
    output logic             TX_Ready,
    output logic             TX_Busy,
    output logic             TX_Done,
    output logic             S_data
);

    localparam int               CNT_W     = $clog2(PKT_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(PKT_W - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    // Explicit encodings so that unused codes exist and fall into the
    // recovery branch of the next-state logic.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       stop_q,  stop_d;
    logic             sdata_q, sdata_d;
    logic             ready_q, ready_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Bit counter increment that holds at the last data bit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= LAST_BIT) begin
            return LAST_BIT;
        end
        return v + CNT_W'(1);
    endfunction

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, so the flops present them in the same cycle as that state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        stop_d   = stop_q;
        sdata_d  = 1'b1;
        ready_d  = 1'b0;
        done_d   = 1'b0;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (TX_Data_Valid && ready_q) begin
                    state_d  = ST_START;
                    shift_d  = TX_Data;
                    count_d  = '0;
                    sdata_d  = 1'b0;
                    ready_d  = 1'b0;
`ifdef TX_PARITY_EN
                    parity_d = ^TX_Data;
`endif
                end
            end

            ST_START: begin
                // Start bit is on the line now; queue bit 0 for the next cycle.
                state_d = ST_DATA;
                count_d = '0;
                sdata_d = shift_q[0];
                shift_d = shift_q >> 1;
            end

            ST_DATA: begin
                // count_q is the index of the bit currently on the line and
                // shift_q[0] already holds the following bit.
                if (count_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                    state_d = ST_PARITY;
                    sdata_d = parity_q;
`else
                    state_d = ST_STOP;
                    sdata_d = 1'b1;
                    stop_d  = '0;
`endif
                end else begin
                    sdata_d = shift_q[0];
                    shift_d = shift_q >> 1;
                    count_d = sat_inc(count_q);
                end
            end

`ifdef TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
                sdata_d = 1'b1;
                stop_d  = '0;
            end
`endif

            ST_STOP: begin
                sdata_d = 1'b1;
                if (stop_q >= LAST_STOP) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    stop_d = stop_q + 2'd1;
                end
            end

            default: begin
                // Unused encoding: return to a clean idle line.
                state_d = ST_IDLE;
                sdata_d = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            count_q  <= '0;
            stop_q   <= '0;
            sdata_q  <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            stop_q   <= stop_d;
            sdata_q  <= sdata_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign S_data   = sdata_q;
    assign TX_Ready = ready_q;
    assign TX_Busy  = busy_q;
    assign TX_Done  = done_q;

endmodule

// File: tb/tb_serial_packet_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_packet_tx
//
// Self-checking bench for serial_packet_tx. A line model expands every accepted
// packet into its list of frame bits and predicts S_data, TX_Ready, TX_Busy and
// TX_Done each cycle; a receiver model decodes S_data and compares the recovered
// packets with the ones accepted. Directed scenarios plus a randomized run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_packet_tx;

    localparam int PKT_W     = 55;
    localparam int STOP_BITS = 1;
`ifdef TX_PARITY_EN
    localparam int PAR       = 1;
`else
    localparam int PAR       = 0;
`endif
    localparam int FRAME_LEN = 1 + PKT_W + PAR + STOP_BITS;
    localparam int TIMEOUT   = 200;

    logic             Clk_S         = 1'b0;
    logic             Rst_n         = 1'b0;
    logic             TX_Data_Valid = 1'b0;
    logic [PKT_W-1:0] TX_Data       = '0;
    logic             TX_Ready;
    logic             TX_Busy;
    logic             TX_Done;
    logic             S_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_packet_tx #(
        .PKT_W    (PKT_W),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .Clk_S        (Clk_S),
        .Rst_n        (Rst_n),
        .TX_Data_Valid(TX_Data_Valid),
        .TX_Data      (TX_Data),
        .TX_Ready     (TX_Ready),
        .TX_Busy      (TX_Busy),
        .TX_Done      (TX_Done),
        .S_data       (S_data)
    );

    always #5 Clk_S = ~Clk_S;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit               line_q[$];
    logic [PKT_W-1:0] pkt_q[$];
    logic             exp_sdata = 1'b1;
    logic             exp_ready = 1'b1;
    logic             exp_busy  = 1'b0;
    logic             exp_done  = 1'b0;
    bit               in_frame  = 1'b0;
    logic             snap_vld;
    logic             snap_rst;
    logic [PKT_W-1:0] snap_data;
    bit               rx_active = 1'b0;
    int               rx_n      = 0;
    logic [PKT_W-1:0] rx_buf    = '0;

    always begin
        @(posedge Clk_S);
        cyc++;
        snap_vld  = TX_Data_Valid;
        snap_data = TX_Data;
        snap_rst  = Rst_n;
        @(negedge Clk_S);
        if (!snap_rst || !Rst_n) begin
            line_q.delete();
            pkt_q.delete();
            exp_sdata = 1'b1;
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            in_frame  = 1'b0;
            rx_active = 1'b0;
        end else begin
            if (snap_vld && exp_ready) begin
                line_q.push_back(1'b0);
                for (int i = 0; i < PKT_W; i++) line_q.push_back(snap_data[i]);
`ifdef TX_PARITY_EN
                line_q.push_back(^snap_data);
`endif
                for (int i = 0; i < STOP_BITS; i++) line_q.push_back(1'b1);
                pkt_q.push_back(snap_data);
            end
            if (line_q.size() > 0) begin
                exp_sdata = line_q.pop_front();
                exp_busy  = 1'b1;
                exp_ready = 1'b0;
                exp_done  = 1'b0;
                in_frame  = 1'b1;
            end else begin
                exp_sdata = 1'b1;
                exp_busy  = 1'b0;
                exp_ready = 1'b1;
                exp_done  = in_frame;
                in_frame  = 1'b0;
            end
        end
        check_val("line_sdata", 64'(S_data),   64'(exp_sdata));
        check_val("line_ready", 64'(TX_Ready), 64'(exp_ready));
        check_val("line_busy",  64'(TX_Busy),  64'(exp_busy));
        check_val("line_done",  64'(TX_Done),  64'(exp_done));

        // receiver: decode frames from the observed line
        if (Rst_n && snap_rst) begin
            if (rx_active) begin
                rx_n++;
                if (rx_n <= PKT_W) begin
                    rx_buf[rx_n-1] = S_data;
`ifdef TX_PARITY_EN
                end else if (rx_n == PKT_W + 1) begin
                    check_val("rx_parity", 64'(S_data), 64'(^rx_buf));
`endif
                end else begin
                    check_val("rx_stop", 64'(S_data), 64'd1);
                    if (rx_n == PKT_W + PAR + STOP_BITS) begin
                        rx_active = 1'b0;
                        check_val("rx_pending", 64'(pkt_q.size() > 0), 64'd1);
                        if (pkt_q.size() > 0) check_val("rx_data", 64'(rx_buf), 64'(pkt_q.pop_front()));
                    end
                end
            end else if (S_data === 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
                rx_buf    = '0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer d with valid high; return the accept edge index and how many
    // ready-high cycles were seen before the accept.
    task automatic send_pkt(input logic [PKT_W-1:0] d, output int k, output int rdy_cycles);
        int guard;
        guard         = 0;
        rdy_cycles    = 0;
        TX_Data       = d;
        TX_Data_Valid = 1'b1;
        while (TX_Ready !== 1'b1 && guard < TIMEOUT) begin
            @(negedge Clk_S);
            guard++;
        end
        while (TX_Ready === 1'b1 && guard < TIMEOUT) begin
            rdy_cycles++;
            @(negedge Clk_S);
            guard++;
        end
        check_val("send_accept", 64'(guard < TIMEOUT), 64'd1);
        k = cyc;
    endtask

    task automatic wait_done(output int e);
        int guard;
        guard = 0;
        while (TX_Done !== 1'b1 && guard < TIMEOUT) begin
            @(negedge Clk_S);
            guard++;
        end
        check_val("done_seen", 64'(guard < TIMEOUT), 64'd1);
        e = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, e, r;
        logic [PKT_W-1:0] d;

        // reset state
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk_S);
        check_val("rst_sdata", 64'(S_data),   64'd1);
        check_val("rst_ready", 64'(TX_Ready), 64'd1);
        check_val("rst_busy",  64'(TX_Busy),  64'd0);
        check_val("rst_done",  64'(TX_Done),  64'd0);
        #1 Rst_n = 1'b1;
        @(negedge Clk_S);

        // single packet
        send_pkt(55'h0AA_5555_0000_F00F, k, r);
        TX_Data_Valid = 1'b0;
        wait_done(e);
        check_val("single_done_lat", 64'(e - k), 64'(FRAME_LEN));

        // back-to-back with valid held high
        @(negedge Clk_S);
        send_pkt(55'h1, k, r);
        send_pkt(55'h7F_FFFF_FFFF_FFFF, k2, r);
        TX_Data_Valid = 1'b0;
        check_val("b2b_period", 64'(k2 - k), 64'(FRAME_LEN + 1));
        check_val("b2b_ready_gap", 64'(r), 64'd1);
        wait_done(e);
        check_val("b2b_done_lat", 64'(e - k2), 64'(FRAME_LEN));

        // valid while busy is ignored
        @(negedge Clk_S);
        d = PKT_W'({$urandom(), $urandom()});
        send_pkt(d, k, r);
        TX_Data_Valid = 1'b0;
        while (cyc < k + 9) @(negedge Clk_S);
        TX_Data       = 55'h3;
        TX_Data_Valid = 1'b1;
        @(negedge Clk_S);
        TX_Data_Valid = 1'b0;
        check_val("busy_ign_ready", 64'(TX_Ready), 64'd0);
        wait_done(e);
        check_val("busy_ign_lat", 64'(e - k), 64'(FRAME_LEN));
        repeat (3) @(negedge Clk_S);
        check_val("busy_ign_idle", 64'(TX_Busy), 64'd0);

        // reset in the middle of a frame
        d = PKT_W'({$urandom(), $urandom()}) & ~PKT_W'(1);
        send_pkt(d, k, r);
        TX_Data_Valid = 1'b0;
        while (cyc < k + 29) @(negedge Clk_S);
        #1 Rst_n = 1'b0;
        #1;
        check_val("rstmid_sdata", 64'(S_data),   64'd1);
        check_val("rstmid_busy",  64'(TX_Busy),  64'd0);
        check_val("rstmid_ready", 64'(TX_Ready), 64'd1);
        @(negedge Clk_S);
        @(negedge Clk_S);
        #1 Rst_n = 1'b1;
        @(negedge Clk_S);
        send_pkt(55'h2A, k, r);
        TX_Data_Valid = 1'b0;
        wait_done(e);
        check_val("rstmid_new_lat", 64'(e - k), 64'(FRAME_LEN));

`ifdef TX_PARITY_EN
        // parity bit value and position
        @(negedge Clk_S);
        send_pkt(55'h7, k, r);
        TX_Data_Valid = 1'b0;
        while (cyc < k + 56) @(negedge Clk_S);
        check_val("par7_bit", 64'(S_data), 64'd1);
        @(negedge Clk_S);
        check_val("par7_stop", 64'(S_data), 64'd1);
        wait_done(e);
        check_val("par7_done_lat", 64'(e - k), 64'd58);
        @(negedge Clk_S);
        send_pkt(55'h3, k, r);
        TX_Data_Valid = 1'b0;
        while (cyc < k + 56) @(negedge Clk_S);
        check_val("par3_bit", 64'(S_data), 64'd0);
        wait_done(e);
`endif

        // randomized run: mix of held-valid and gapped packets
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:       d = '0;
                1:       d = '1;
                default: d = PKT_W'({$urandom(), $urandom()});
            endcase
            send_pkt(d, k, r);
            if ($urandom_range(0, 1) == 0) begin
                TX_Data_Valid = 1'b0;
                wait_done(e);
                check_val("rnd_done_lat", 64'(e - k), 64'(FRAME_LEN));
                repeat ($urandom_range(0, 3)) @(negedge Clk_S);
            end
        end
        TX_Data_Valid = 1'b0;
        repeat (FRAME_LEN + 5) @(negedge Clk_S);
        check_val("end_idle_busy", 64'(TX_Busy), 64'd0);
        check_val("end_all_rx", 64'(pkt_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
